// File: rtl/sample_requester_pkg.sv
// Shared types and helpers for the sample requester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sample_requester_pkg;

    localparam int SAMPLE_W_DEF = 16;

    typedef enum logic [1:0] {
        WAIT_TICK  = 2'd0,
        REQUEST    = 2'd1,
        WAIT_READY = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..limit-1 (at least one bit).
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Pacing counter: emits a one-cycle tick every PERIOD enabled cycles.
// Latency: tick is combinational on the final count; first tick PERIOD-1 cycles after en rises.
// Backpressure: none; counter is held at zero while en is low.
module tick_divider
    import sample_requester_pkg::*;
#(
    parameter int PERIOD = 2083
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int              CW   = cnt_w(PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // Free-running modulo-PERIOD count while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!en || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/sample_requester.sv
// Paces generate_next requests, captures returned samples, flags missed responses (optional SAMPLE_COUNT_EN adds sample_count).
// Latency: generate_next one cycle after tick; sample_out/sample_valid one cycle after sample_ready (or after TIMEOUT idle cycles).
// Backpressure: none downstream; producer silence is absorbed by the timeout and sticky underrun flag.
module sample_requester
    import sample_requester_pkg::*;
#(
    parameter int PERIOD   = 2083,
    parameter int TIMEOUT  = 16,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                clear_underrun,
    output logic                generate_next,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
`ifdef SAMPLE_COUNT_EN
    output logic [15:0]         sample_count,
`endif
    output logic                underrun
);

    localparam int            WCW       = cnt_w(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    logic           tick;
    logic [WCW-1:0] wait_cnt;
    logic           capture;
    logic           time_out;

    tick_divider #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_TICK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; sample_ready only matters while waiting for a response.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        time_out  = 1'b0;
        case (state)
            WAIT_TICK: begin
                if (tick) state_nxt = REQUEST;
            end
            REQUEST: begin
                state_nxt = WAIT_READY;
            end
            WAIT_READY: begin
                if (sample_ready) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_TICK;
                end else if (wait_cnt == WAIT_LAST) begin
                    time_out  = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            default: begin
                state_nxt = WAIT_TICK;
            end
        endcase
    end

    // Wait counter: cleared in the request cycle, counts cycles spent waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == REQUEST) begin
            wait_cnt <= '0;
        end else if (state == WAIT_READY) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Registered request pulse; REQUEST always exits after one cycle, so no back-to-back pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            generate_next <= 1'b0;
        end else begin
            generate_next <= (state_nxt == REQUEST);
        end
    end

    // Capture register and refresh strobe; a timeout re-presents the held sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= capture | time_out;
            if (capture) sample_out <= sample_in;
        end
    end

    // Sticky underrun: a timeout in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if (time_out) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

`ifdef SAMPLE_COUNT_EN
    // Count of genuinely captured samples, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_count <= '0;
        end else if (capture) begin
            sample_count <= sample_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_requester.sv
module tb_sample_requester;

    localparam int PERIOD  = 8;
    localparam int TIMEOUT = 4;
    localparam int SW      = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          sample_ready;
    logic [SW-1:0] sample_in;
    logic          clear_underrun;
    logic          generate_next;
    logic [SW-1:0] sample_out;
    logic          sample_valid;
    logic          underrun;
`ifdef SAMPLE_COUNT_EN
    logic [15:0]   sample_count;
`endif

    always #5 clk = ~clk;

    sample_requester #(
        .PERIOD   (PERIOD),
        .TIMEOUT  (TIMEOUT),
        .SAMPLE_W (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .sample_ready   (sample_ready),
        .sample_in      (sample_in),
        .clear_underrun (clear_underrun),
        .generate_next  (generate_next),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
`ifdef SAMPLE_COUNT_EN
        .sample_count   (sample_count),
`endif
        .underrun       (underrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: what the consumer should currently be presenting.
    logic [SW-1:0] m_out;
    logic          m_ur;
    int            m_cnt;
    int            prev_g;

    typedef struct {
        int            k;        // response latency after generate_next; > TIMEOUT means no response
        logic [SW-1:0] data;
        bit            spur;     // drive 16'hDEAD with ready while idle and in the request cycle
        logic [SW-1:0] exp_out;
        logic          exp_ur;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One request/response exchange, checked cycle by cycle against the model.
    task automatic do_txn(input int k, input logic [SW-1:0] data, input bit spur, input bit en_drop,
                          input bit clr_coll, input logic [SW-1:0] exp_out, input logic exp_ur,
                          input string name);
        int n;
        int g;
        bit done;
        n = 0;
        sample_ready = spur;
        sample_in    = 16'hDEAD;
        while (generate_next !== 1'b1 && n < 3 * PERIOD) begin
            check({name, "_idle_valid"}, sample_valid, 1'b0);
            check({name, "_idle_out"}, sample_out, m_out);
            step;
            n++;
        end
        check({name, "_gen_seen"}, generate_next, 1'b1);
        if (generate_next !== 1'b1) return;
        g = cyc;
        if (prev_g >= 0) check({name, "_gen_spacing"}, g - prev_g, PERIOD);
        prev_g = g;
        done = 1'b0;
        for (int i = 1; i <= TIMEOUT + 1 && !done; i++) begin
            step;
            if (i == 1) begin
                check({name, "_gen_one_cycle"}, generate_next, 1'b0);
                if (en_drop) en = 1'b0;
            end
            if ((k <= TIMEOUT && i == k + 1) || (k > TIMEOUT && i == TIMEOUT + 1)) begin
                check({name, "_valid"}, sample_valid, 1'b1);
                check({name, "_out"}, sample_out, exp_out);
                check({name, "_underrun"}, underrun, exp_ur);
`ifdef SAMPLE_COUNT_EN
                check({name, "_count"}, sample_count, 32'(m_cnt + ((k <= TIMEOUT) ? 1 : 0)));
`endif
                done = 1'b1;
            end else begin
                check({name, "_wait_valid"}, sample_valid, 1'b0);
                check({name, "_wait_out"}, sample_out, m_out);
                check({name, "_wait_underrun"}, underrun, m_ur);
            end
            sample_ready   = (i == k);
            sample_in      = (i == k) ? data : 16'hDEAD;
            clear_underrun = clr_coll && (i == TIMEOUT);
        end
        sample_ready   = 1'b0;
        clear_underrun = 1'b0;
        m_out = exp_out;
        m_ur  = exp_ur;
        if (k <= TIMEOUT) m_cnt++;
        step;
        check({name, "_valid_pulse"}, sample_valid, 1'b0);
    endtask

    task automatic pulse_clear(input string name);
        clear_underrun = 1'b1;
        step;
        clear_underrun = 1'b0;
        m_ur = 1'b0;
        check(name, underrun, 1'b0);
    endtask

    initial begin
        int n;
        int k;
        logic [SW-1:0] d;

        vecs[0] = '{1, 16'h1234, 1'b0, 16'h1234, 1'b0};
        vecs[1] = '{1, 16'h1234, 1'b0, 16'h1234, 1'b0};
        vecs[2] = '{4, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0};
        vecs[3] = '{5, 16'h0000, 1'b0, 16'hBEEF, 1'b1};
        vecs[4] = '{2, 16'h5A5A, 1'b1, 16'h5A5A, 1'b1};

        reset = 1'b0; en = 1'b0; sample_ready = 1'b0; sample_in = '0; clear_underrun = 1'b0;
        m_out = '0; m_ur = 1'b0; m_cnt = 0; prev_g = -1;

        step;
        step;
        check("rst_gen", generate_next, 1'b0);
        check("rst_out", sample_out, 16'h0000);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_underrun", underrun, 1'b0);
`ifdef SAMPLE_COUNT_EN
        check("rst_count", sample_count, 16'h0000);
`endif

        // First request lands PERIOD cycles after enable.
        reset = 1'b1;
        step;
        en = 1'b1;
        for (int j = 1; j <= PERIOD; j++) begin
            step;
            check("first_gen", generate_next, (j == PERIOD) ? 1'b1 : 1'b0);
        end

        for (int v = 0; v < 5; v++)
            do_txn(vecs[v].k, vecs[v].data, vecs[v].spur, 1'b0, 1'b0,
                   vecs[v].exp_out, vecs[v].exp_ur, $sformatf("vec%0d", v));

        pulse_clear("clear_underrun");

        // Clear coincident with timeout: the timeout must win.
        do_txn(TIMEOUT + 1, 16'h0000, 1'b0, 1'b0, 1'b1, m_out, 1'b1, "collision");
        pulse_clear("clear_after_collision");

        // Enable dropped right after the request; outstanding answer still captured.
        do_txn(4, 16'h00AA, 1'b0, 1'b1, 1'b0, 16'h00AA, m_ur, "en_drop");
        for (int j = 0; j < 20; j++) begin
            step;
            check("en_off_no_gen", generate_next, 1'b0);
        end
        en = 1'b1;
        for (int j = 1; j <= PERIOD; j++) begin
            step;
            check("en_back_gen", generate_next, (j == PERIOD) ? 1'b1 : 1'b0);
        end
        prev_g = -1;
        do_txn(1, 16'hC0DE, 1'b0, 1'b0, 1'b0, 16'hC0DE, m_ur, "after_en");

        // Reset while waiting for a response; a late ready must be ignored.
        n = 0;
        while (generate_next !== 1'b1 && n < 3 * PERIOD) begin
            step;
            n++;
        end
        check("mid_rst_gen_seen", generate_next, 1'b1);
        step;
        step;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_gen", generate_next, 1'b0);
        check("mid_rst_out", sample_out, 16'h0000);
        check("mid_rst_valid", sample_valid, 1'b0);
        check("mid_rst_underrun", underrun, 1'b0);
`ifdef SAMPLE_COUNT_EN
        check("mid_rst_count", sample_count, 16'h0000);
`endif
        step;
        step;
        reset = 1'b1;
        sample_ready = 1'b1;
        sample_in = 16'h5555;
        for (int j = 0; j < 4; j++) begin
            step;
            check("late_ready_valid", sample_valid, 1'b0);
            check("late_ready_out", sample_out, 16'h0000);
        end
        sample_ready = 1'b0;
        m_out = '0; m_ur = 1'b0; m_cnt = 0; prev_g = -1;

        // Randomized exchanges against the model.
        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(1, TIMEOUT + 1);
            d = SW'($urandom);
            do_txn(k, d, ($urandom_range(0, 3) == 0), 1'b0, 1'b0,
                   (k <= TIMEOUT) ? d : m_out, m_ur | (k > TIMEOUT), $sformatf("rnd%0d", r));
            if ($urandom_range(0, 2) == 0) pulse_clear("rnd_clear");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
